// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester and its wait timer.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states. Flags expiry on the cycle that would be the TIMEOUT-th consecutive wait.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // Saturating: holds at TIMEOUT rather than wrapping back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != MAX) begin
            count <= count + 1'b1;
        end
    end

    // count holds the waits already seen, so expiry is combinational on the current one.
    assign expired = (TIMEOUT > 0) && enable && (count >= LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: one valid/ready command in flight, run as SETUP/ACCESS, one response pulse per command.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    apb_state_e state;
    logic       expired;
    logic       accept;

    // pready reaches cmd_ready combinationally so a completing ACCESS can take the next command.
    assign cmd_ready = (state == IDLE) || ((state == ACCESS) && pready);
    assign accept    = cmd_valid && cmd_ready;

    apb_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != ACCESS),
        .enable ((state == ACCESS) && !pready),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_write ? cmd_wdata : '0;
            end
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state <= SETUP;
                        psel  <= 1'b1;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        penable   <= 1'b0;
                        if (cmd_valid) begin
                            state <= SETUP;
                        end else begin
                            state <= IDLE;
                            psel  <= 1'b0;
                        end
                    end else if (expired) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: behavioural APB completer, response scoreboard, directed timing steps.
module tb_apb_master;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    logic [31:0] mem [0:63];
    int          waits = 0;
    logic        stuck = 1'b0;
    int          acc_cnt = 0;
    int          compared = 0;
    int          mismatched = 0;
    exp_t        sb_q[$];
    exp_t        e;

    apb_master #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .psel     (psel),
        .penable  (penable),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready)
    );

    always #5 clk = ~clk;

    // Completer: 'waits' wait states per ACCESS, or never ready while 'stuck'.
    assign prdata = (psel && !pwrite) ? mem[paddr[7:2]] : '0;
    assign pready = !stuck && (acc_cnt >= waits);

    always @(posedge clk) begin
        if (psel && penable && pready && pwrite) mem[paddr[7:2]] = pwdata;
        if (!(psel && penable)) acc_cnt <= 0;
        else if (!pready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response side of the scoreboard.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 64'(sb_q.size()), 64'(1));
            end else begin
                e = sb_q.pop_front();
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    // Present a command in the current (IDLE) cycle; returns in the SETUP cycle.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = ~w;
        cmd_addr  = 32'hFFFF_FFFC;
        cmd_wdata = 32'h0BAD_0BAD;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);

        // Reset state
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_psel", 64'(psel), 64'(0));
        check("rst_penable", 64'(penable), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait write of 0xDEADBEEF to 0x10
        sb_q.push_back('{rdata: 32'h0, err: 1'b0});
        send(1'b1, 32'h10, 32'hDEAD_BEEF);
        check("wr_setup_psel", 64'(psel), 64'(1));
        check("wr_setup_penable", 64'(penable), 64'(0));
        check("wr_paddr", 64'(paddr), 64'h10);
        check("wr_pwrite", 64'(pwrite), 64'(1));
        check("wr_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
        @(negedge clk);
        check("wr_access_penable", 64'(penable), 64'(1));
        check("wr_access_psel", 64'(psel), 64'(1));
        @(negedge clk);
        check("wr_rsp_valid", 64'(rsp_valid), 64'(1));
        check("wr_psel_drop", 64'(psel), 64'(0));
        check("wr_mem", 64'(mem[4]), 64'hDEAD_BEEF);
        @(negedge clk);
        check("wr_rsp_pulse", 64'(rsp_valid), 64'(0));

        // Read back 0x10
        sb_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
        send(1'b0, 32'h10, 32'h5555_5555);
        check("rd_pwrite", 64'(pwrite), 64'(0));
        check("rd_pwdata", 64'(pwdata), 64'(0));
        @(negedge clk);
        @(negedge clk);
        check("rd_rsp_valid", 64'(rsp_valid), 64'(1));
        @(negedge clk);

        // Three wait states on a read of 0x20
        waits = 3;
        sb_q.push_back('{rdata: 32'hC0DE_0008, err: 1'b0});
        send(1'b0, 32'h20, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ws_penable", 64'(penable), 64'(1));
            check("ws_paddr", 64'(paddr), 64'h20);
            check("ws_no_rsp", 64'(rsp_valid), 64'(0));
        end
        @(negedge clk);
        check("ws_rsp_valid", 64'(rsp_valid), 64'(1));
        waits = 0;
        @(negedge clk);

        // Back-to-back: write 0x04 then read 0x08 with cmd_valid held
        sb_q.push_back('{rdata: 32'h0, err: 1'b0});
        sb_q.push_back('{rdata: 32'hC0DE_0002, err: 1'b0});
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h04;
        cmd_wdata = 32'hA5A5_0004;
        @(negedge clk);
        cmd_write = 1'b0;
        cmd_addr  = 32'h08;
        cmd_wdata = 32'h0;
        check("b2b_setup1_paddr", 64'(paddr), 64'h04);
        check("b2b_setup1_ready", 64'(cmd_ready), 64'(0));
        @(negedge clk);
        check("b2b_access1_ready", 64'(cmd_ready), 64'(1));
        check("b2b_access1_penable", 64'(penable), 64'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_setup2_psel", 64'(psel), 64'(1));
        check("b2b_setup2_penable", 64'(penable), 64'(0));
        check("b2b_setup2_paddr", 64'(paddr), 64'h08);
        check("b2b_rsp1", 64'(rsp_valid), 64'(1));
        check("b2b_mem", 64'(mem[1]), 64'hA5A5_0004);
        @(negedge clk);
        check("b2b_access2_psel", 64'(psel), 64'(1));
        check("b2b_gap", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        check("b2b_rsp2", 64'(rsp_valid), 64'(1));
        @(negedge clk);

        // Timeout: pready stuck low
        stuck = 1'b1;
        sb_q.push_back('{rdata: 32'h0, err: 1'b1});
        send(1'b0, 32'h30, 32'h0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("to_waiting", 64'({psel, penable, rsp_valid}), 64'b110);
        end
        @(negedge clk);
        check("to_psel_drop", 64'(psel), 64'(0));
        check("to_rsp_valid", 64'(rsp_valid), 64'(1));
        check("to_cmd_ready", 64'(cmd_ready), 64'(1));
        stuck = 1'b0;
        @(negedge clk);

        // Reset asserted mid-ACCESS
        waits = 5;
        sb_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
        send(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        check("rr_in_access", 64'(penable), 64'(1));
        #2 reset = 1'b1;
        #1;
        check("rr_async", 64'({psel, penable, rsp_valid}), 64'b000);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        waits = 0;
        check("rr_cmd_ready", 64'(cmd_ready), 64'(1));
        repeat (8) @(negedge clk);
        check("rr_idle_psel", 64'(psel), 64'(0));
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
